// File: rtl/stonyman_capture_seq_if.sv
// Capture-sequencer bundle: register-block start/abort, sensor pins, SPI ADC
// handshake and pixel-FIFO write port.
interface stonyman_capture_seq_if #(
    parameter int unsigned ADC_W  = 10,
    parameter int unsigned FIFO_W = 16
);
    logic              start;
    logic              abort;
    logic              resv;
    logic              resp;
    logic              incv;
    logic              incp;
    logic              inphi;
    logic              adc_start;
    logic              adc_done;
    logic [ADC_W-1:0]  adc_data;
    logic              fifo_wren;
    logic [FIFO_W-1:0] fifo_wdata;
    logic              fifo_full;
    logic              busy;
    logic              done;
    logic              adc_err;

    modport master (
        input  start, abort, adc_done, adc_data, fifo_full,
        output resv, resp, incv, incp, inphi, adc_start,
               fifo_wren, fifo_wdata, busy, done, adc_err
    );

    modport slave (
        output start, abort, adc_done, adc_data, fifo_full,
        input  resv, resp, incv, incp, inphi, adc_start,
               fifo_wren, fifo_wdata, busy, done, adc_err
    );
endinterface

// File: rtl/stonyman_capture_seq.sv
// Stonyman frame-capture sequencer: walks the pixel array with the sensor
// pointer pins, converts each pixel via the SPI ADC and writes it to the FIFO.
module stonyman_capture_seq #(
    parameter int unsigned ROWS        = 112,
    parameter int unsigned COLS        = 112,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned SETTLE_CYC  = 10,
    parameter int unsigned ADC_W       = 10,
    parameter int unsigned FIFO_W      = 16,
    parameter int unsigned ADC_TIMEOUT = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESETN,
    stonyman_capture_seq_if.master bus
);
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned TMAX1 = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned TMAX  = (TMAX1 > ADC_TIMEOUT) ? TMAX1 : ADC_TIMEOUT;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RESV, S_ROWRST, S_PHI, S_SETTLE, S_CONV,
        S_WAIT, S_WRITE, S_INCP, S_INCV, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [ADC_W-1:0]  sample_q, sample_d;
    logic              err_q, err_d;
    logic [4:0]        pins_q, pins_d;  // {resv, resp, incv, incp, inphi}
    logic              adc_start_q, adc_start_d;
    logic              wren_q, wren_d;
    logic [FIFO_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pulse_end, pulse_on, last_col, last_row;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sample_q    <= '0;
            err_q       <= 1'b0;
            pins_q      <= '0;
            adc_start_q <= 1'b0;
            wren_q      <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sample_q    <= sample_d;
            err_q       <= err_d;
            pins_q      <= pins_d;
            adc_start_q <= adc_start_d;
            wren_q      <= wren_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Pulse states hold their pin for PULSE_CYC clocks then spend one low
    // clock before leaving, so adjacent pulses never touch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        row_d     = row_q;
        col_d     = col_q;
        sample_d  = sample_q;
        err_d     = err_q;
        wren_d    = 1'b0;
        wdata_d   = '0;
        pulse_end = (timer_q == TW'(PULSE_CYC));
        last_col  = (col_q == CW'(COLS - 1));
        last_row  = (row_q == RW'(ROWS - 1));

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RESV;
                    err_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RESV:   if (pulse_end) state_d = S_ROWRST;
            S_ROWRST: begin
                col_d = '0;
                if (pulse_end) state_d = S_PHI;
            end
            S_PHI:    if (pulse_end) state_d = S_SETTLE;
            S_SETTLE: if (timer_q == TW'(SETTLE_CYC - 1)) state_d = S_CONV;
            S_CONV:   state_d = S_WAIT;
            S_WAIT: begin
                if (bus.adc_done) begin
                    sample_d = bus.adc_data;
                    state_d  = S_WRITE;
                end else if (timer_q == TW'(ADC_TIMEOUT - 1)) begin
                    sample_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bus.fifo_full) begin
                    wren_d                = 1'b1;
                    wdata_d[ADC_W-1:0]    = sample_q;
                    wdata_d[FIFO_W-1]     = (row_q == '0) && (col_q == '0);
                    if (!last_col)      state_d = S_INCP;
                    else if (!last_row) state_d = S_INCV;
                    else                state_d = S_DONE;
                end
            end
            S_INCP: begin
                if (pulse_end) begin
                    col_d   = col_q + CW'(1);
                    state_d = S_PHI;
                end
            end
            S_INCV: begin
                if (pulse_end) begin
                    row_d   = row_q + RW'(1);
                    state_d = S_ROWRST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything this clock but keeps the error flag.
        if (bus.abort) begin
            state_d = S_IDLE;
            err_d   = err_q;
            row_d   = '0;
            col_d   = '0;
            wren_d  = 1'b0;
            wdata_d = '0;
        end

        if ((state_d != state_q) || (state_d == S_IDLE)) timer_d = '0;

        pulse_on    = (timer_d < TW'(PULSE_CYC));
        pins_d      = {(state_d == S_RESV)   && pulse_on,
                       (state_d == S_ROWRST) && pulse_on,
                       (state_d == S_INCV)   && pulse_on,
                       (state_d == S_INCP)   && pulse_on,
                       (state_d == S_PHI)    && pulse_on};
        adc_start_d = (state_d == S_CONV);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    assign bus.resv       = pins_q[4];
    assign bus.resp       = pins_q[3];
    assign bus.incv       = pins_q[2];
    assign bus.incp       = pins_q[1];
    assign bus.inphi      = pins_q[0];
    assign bus.adc_start  = adc_start_q;
    assign bus.fifo_wren  = wren_q;
    assign bus.fifo_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.adc_err    = err_q;
endmodule
